// File: rtl/tlc5957_poker_driver.sv
// Serialiser for a daisy chain of TLC5957 drivers in poker mode: turns bit-plane
// words and two-step function-control writes into SCLK/SIN/LAT bit periods.
module tlc5957_poker_driver #(
  parameter int N_CHIPS  = 1,
  parameter int BITS     = 16,
  parameter int SCLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [48*N_CHIPS-1:0] plane_data,
  input  logic                  plane_valid,
  output logic                  plane_ready,
  input  logic [48*N_CHIPS-1:0] fc_data,
  input  logic                  fc_valid,
  output logic                  fc_ready,
  output logic                  SCLK,
  output logic                  SIN,
  output logic                  LAT,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int L     = 48 * N_CHIPS;
  localparam int CNT_W = $clog2(L + 1);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_SHIFT  = CNT_W'(L);
  localparam logic [CNT_W-1:0] CNT_FC_EN  = CNT_W'(15);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
  localparam logic [3:0]       LAST_PLANE = 4'(BITS - 1);
  localparam logic [2:0]       LEN_WRTGS  = 3'd1;
  localparam logic [2:0]       LEN_LATGS  = 3'd3;
  localparam logic [2:0]       LEN_WRTFC  = 3'd5;

  typedef enum logic [2:0] {IDLE, FC_EN, FC_GAP, SHIFT, TRAIL} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [L-1:0]     shreg_reg, shreg_next;
  logic [2:0]       lat_len_reg, lat_len_next;
  logic [3:0]       plane_idx_reg, plane_idx_next;
  logic             is_plane_reg, is_plane_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             sclk_reg, sclk_next;
  logic             sin_reg, sin_next;
  logic             lat_reg, lat_next;
  logic             frame_done_reg, frame_done_next;
  logic             ready_en_reg;
  logic             idle_ok;
  logic             fc_take;
  logic             plane_take;
  logic             bit_end;

  // Handshakes stay closed for the first cycle after reset release.
  assign idle_ok     = (state_reg == IDLE) && ready_en_reg;
  assign fc_ready    = idle_ok && (plane_idx_reg == 4'd0);
  assign plane_ready = idle_ok && (!fc_valid || (plane_idx_reg != 4'd0));
  assign fc_take     = fc_ready && fc_valid;
  assign plane_take  = plane_ready && plane_valid && !fc_take;

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shreg_next      = shreg_reg;
    lat_len_next    = lat_len_reg;
    plane_idx_next  = plane_idx_reg;
    is_plane_next   = is_plane_reg;
    div_cnt_next    = div_cnt_reg;
    sclk_next       = sclk_reg;
    frame_done_next = 1'b0;
    bit_end         = 1'b0;

    if (state_reg == IDLE) begin
      sclk_next    = 1'b0;
      div_cnt_next = '0;
      if (fc_take) begin
        state_next    = FC_EN;
        bit_cnt_next  = CNT_FC_EN;
        shreg_next    = fc_data;
        lat_len_next  = LEN_WRTFC;
        is_plane_next = 1'b0;
      end else if (plane_take) begin
        state_next    = SHIFT;
        bit_cnt_next  = CNT_SHIFT;
        shreg_next    = plane_data;
        lat_len_next  = (plane_idx_reg == LAST_PLANE) ? LEN_LATGS : LEN_WRTGS;
        is_plane_next = 1'b1;
      end
    end else begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_next = '0;
        sclk_next    = ~sclk_reg;
        bit_end      = sclk_reg;
      end else begin
        div_cnt_next = div_cnt_reg + 1'b1;
      end
    end

    // A bit period ends when the high phase expires; the next bit starts low.
    if (bit_end) begin
      case (state_reg)
        FC_EN: begin
          if (bit_cnt_reg == CNT_ONE) begin
            state_next   = FC_GAP;
            bit_cnt_next = CNT_ONE;
          end else begin
            bit_cnt_next = bit_cnt_reg - CNT_ONE;
          end
        end
        FC_GAP: begin
          state_next   = SHIFT;
          bit_cnt_next = CNT_SHIFT;
        end
        SHIFT: begin
          shreg_next = {shreg_reg[L-2:0], 1'b0};
          if (bit_cnt_reg == CNT_ONE) begin
            state_next   = TRAIL;
            bit_cnt_next = CNT_ONE;
          end else begin
            bit_cnt_next = bit_cnt_reg - CNT_ONE;
          end
        end
        TRAIL: begin
          state_next = IDLE;
          if (is_plane_reg) begin
            if (plane_idx_reg == LAST_PLANE) begin
              plane_idx_next  = 4'd0;
              frame_done_next = 1'b1;
            end else begin
              plane_idx_next = plane_idx_reg + 4'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // SIN/LAT are derived from the upcoming bit so they only move at low-phase start.
    sin_next = (state_next == SHIFT) ? shreg_next[L-1] : 1'b0;
    lat_next = (state_next == FC_EN) ||
               ((state_next == SHIFT) && (bit_cnt_next <= CNT_W'(lat_len_next)));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shreg_reg      <= '0;
      lat_len_reg    <= LEN_WRTGS;
      plane_idx_reg  <= 4'd0;
      is_plane_reg   <= 1'b0;
      div_cnt_reg    <= '0;
      sclk_reg       <= 1'b0;
      sin_reg        <= 1'b0;
      lat_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
      ready_en_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shreg_reg      <= shreg_next;
      lat_len_reg    <= lat_len_next;
      plane_idx_reg  <= plane_idx_next;
      is_plane_reg   <= is_plane_next;
      div_cnt_reg    <= div_cnt_next;
      sclk_reg       <= sclk_next;
      sin_reg        <= sin_next;
      lat_reg        <= lat_next;
      frame_done_reg <= frame_done_next;
      ready_en_reg   <= 1'b1;
    end
  end

  assign SCLK       = sclk_reg;
  assign SIN        = sin_reg;
  assign LAT        = lat_reg;
  assign busy       = (state_reg != IDLE);
  assign frame_done = frame_done_reg;

endmodule
